// File: rtl/mem_arbiter.sv
// Shares one single-port, 1-cycle-latency memory between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed LS priority with IF guard.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [3:0]            ls_be,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StIfPend, StLsPend} state_e;

  state_e state_q, state_d;
  logic   if_win;
  logic   if_gnt_raw, ls_gnt_raw;

`ifdef MEM_ARB_RR_EN
  typedef enum logic {OwnerIf, OwnerLs} owner_e;
  owner_e last_owner_q, last_owner_d;

  always_comb begin
    if_win       = (last_owner_q == OwnerLs);
    last_owner_d = last_owner_q;
    if (if_gnt_raw) begin
      last_owner_d = OwnerIf;
    end else if (ls_gnt_raw) begin
      last_owner_d = OwnerLs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= OwnerIf;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    if_win       = (starve_cnt_q == StarveMax);
    starve_cnt_d = starve_cnt_q;
    if (if_gnt_raw || !if_req) begin
      starve_cnt_d = '0;
    end else if (ls_gnt_raw && (starve_cnt_q != StarveMax)) begin
      starve_cnt_d = starve_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  always_comb begin
    if_gnt_raw = 1'b0;
    ls_gnt_raw = 1'b0;
    if (if_req && ls_req) begin
      if_gnt_raw = if_win;
      ls_gnt_raw = !if_win;
    end else begin
      if_gnt_raw = if_req;
      ls_gnt_raw = ls_req;
    end
  end

  // Reset masks only the visible handshake so it never feeds back into the flops' D inputs.
  always_comb begin
    if_gnt    = if_gnt_raw & rst_n;
    ls_gnt    = ls_gnt_raw & rst_n;
    mem_en    = if_gnt | ls_gnt;
    mem_we    = (ls_gnt && ls_we) ? ls_be : 4'b0000;
    mem_addr  = ls_gnt_raw ? ls_addr : if_addr;
    mem_wdata = ls_gnt_raw ? ls_wdata : '0;
  end

  always_comb begin
    state_d = StIdle;
    if (if_gnt_raw) begin
      state_d = StIfPend;
    end else if (ls_gnt_raw) begin
      state_d = StLsPend;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    if_rvalid = (state_q == StIfPend);
    ls_rvalid = (state_q == StLsPend);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    ls_rdata  = ls_rvalid ? mem_rdata : '0;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, byte-address width on all ports.
REQ-002 Parameter: DATA_WIDTH, 32, data width on all ports; fixed at 32 for rv32i.
REQ-003 Parameter: STARVE_LIMIT, 4, max consecutive LS grants while IF waits (fixed-priority mode only).
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: if_req  input  1  fetch request; held with if_addr stable until if_gnt.
REQ-007 Port: if_addr  input  ADDR_WIDTH  fetch byte address.
REQ-008 Port: if_gnt  output  1  fetch accepted this cycle.
REQ-009 Port: if_rvalid  output  1  fetch data valid.
REQ-010 Port: if_rdata  output  DATA_WIDTH  fetch data.
REQ-011 Port: ls_req  input  1  load/store request; held with ls_* stable until ls_gnt.
REQ-012 Port: ls_we  input  1  1 = store, 0 = load.
REQ-013 Port: ls_be  input  4  store byte enables.
REQ-014 Port: ls_addr  input  ADDR_WIDTH  load/store byte address.
REQ-015 Port: ls_wdata  input  DATA_WIDTH  store data.
REQ-016 Port: ls_gnt  output  1  load/store accepted this cycle.
REQ-017 Port: ls_rvalid  output  1  load data valid / store completion.
REQ-018 Port: ls_rdata  output  DATA_WIDTH  load data.
REQ-019 Port: mem_en  output  1  memory access strobe.
REQ-020 Port: mem_we  output  4  per-byte write enable.
REQ-021 Port: mem_addr  output  ADDR_WIDTH  memory byte address.
REQ-022 Port: mem_wdata  output  DATA_WIDTH  memory write data.
REQ-023 Port: mem_rdata  input  DATA_WIDTH  read data, valid one cycle after mem_en.

Function
REQ-024 Block SHALL share one single-port, 1-cycle-latency memory between fetch (IF) and load/store (LS).
REQ-025 Grant SHALL be combinational in the request cycle; at most one of if_gnt/ls_gnt high per cycle.
REQ-026 Single requester SHALL be granted immediately; no requester -> mem_en=0, mem_we=0.
REQ-027 Both requesting, fixed mode: LS wins unless starve_cnt==STARVE_LIMIT, then IF wins.
REQ-028 starve_cnt SHALL increment on each LS grant while if_req=1, clear on IF grant or if_req=0, saturate at STARVE_LIMIT.
REQ-029 mem_en = if_gnt|ls_gnt; mem_addr/mem_wdata from granted port; mem_we = ls_be when ls_gnt&ls_we, else 0.
REQ-030 FSM states IDLE, IF_PEND, LS_PEND; next state IF_PEND on if_gnt, LS_PEND on ls_gnt, else IDLE; evaluated every cycle (back-to-back grants allowed).
REQ-031 if_rvalid=1 only in IF_PEND; ls_rvalid=1 only in LS_PEND (loads and stores).
REQ-032 x_rdata SHALL equal mem_rdata while x_rvalid=1, else 0.
REQ-033 Throughput: one grant per cycle; grant-to-rvalid latency exactly 1 cycle.

Reset
REQ-034 On rst_n=0: state IDLE, starve_cnt=0, last_owner=IF; if_rvalid=ls_rvalid=0; if_rdata=ls_rdata=0.
REQ-035 Grants/mem_en SHALL be 0 while rst_n=0; an access pending at reset assertion SHALL be dropped without rvalid.

Configuration
REQ-036 Macro MEM_ARB_RR_EN defined: on simultaneous requests, grant the port not granted last (last_owner register, updated on every grant); starve_cnt and STARVE_LIMIT unused.
REQ-037 MEM_ARB_RR_EN undefined: fixed LS priority with starvation guard per REQ-027/028.

Verification
REQ-038 IF-only: if_req=1, if_addr=0x00000010, mem_rdata=0x00500093 next cycle -> if_gnt same cycle, if_rvalid=1 with if_rdata=0x00500093 one cycle later.
REQ-039 Store: ls_req=1, ls_we=1, ls_be=4'b0011, ls_addr=0x100, ls_wdata=0xDEADBEEF -> mem_we=4'b0011, mem_addr=0x100, ls_rvalid=1 next cycle, if_rvalid=0.
REQ-040 Contention, fixed mode, STARVE_LIMIT=4: if_req and ls_req held high 6 cycles -> grants LS,LS,LS,LS,IF,LS.
REQ-041 Contention, MEM_ARB_RR_EN defined: both held high from reset 4 cycles -> grants LS,IF,LS,IF.
REQ-042 Reset mid-access: ls_gnt in cycle N, rst_n=0 before edge N+1 -> ls_rvalid stays 0, state IDLE after release.
REQ-043 Back-to-back: IF granted cycles N and N+1 with mem_rdata A then B -> if_rvalid high N+1 and N+2, data A then B.
